// File: rtl/stream_acc_pkg.sv
// stream_acc_pkg
// Shared types and helpers for the stream accumulator slice.
//   state_t   : frame FSM states (IDLE, ACCUM, HOLD)
//   cnt_width : width of the beat counter able to hold 0..count
package stream_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Width needed to count from 0 up to and including count.
  function automatic int cnt_width(input int count);
    return (count < 1) ? 1 : $clog2(count + 1);
  endfunction

endpackage

// File: rtl/acc_rca.sv
// acc_rca
// Ripple-carry adder of W bits built from a generate loop of full adders.
// Ports:
//   a, b  input  W  addends
//   cin   input  1  carry into bit 0
//   sum   output W  a + b + cin, modulo 2^W
//   cout  output 1  carry out of bit W-1
module acc_rca
  import stream_acc_pkg::*;
#(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[W];

endmodule

// File: rtl/stream_accumulator.sv
// stream_accumulator
// Adds COUNT unsigned operands received over a valid/ready input into an
// ACC_W-bit running sum, then presents the frame total and a sticky
// overflow flag on a valid/ready output before clearing for the next frame.
// Optional build macro: STREAM_ACC_SATURATE_EN -- when defined, the
// accumulator clamps to all-ones on the first carry out and stays there for
// the rest of the frame; otherwise it wraps modulo 2^ACC_W.
// Ports:
//   clk        input   1       clock, rising edge
//   rst        input   1       synchronous active-high reset
//   in_valid   input   1       operand valid
//   in_ready   output  1       operand can be accepted (low while holding)
//   in_data    input   DATA_W  unsigned operand, zero-extended to ACC_W
//   out_valid  output  1       frame result valid
//   out_ready  input   1       downstream accepts the result
//   out_sum    output  ACC_W   frame total
//   out_ovf    output  1       a carry out occurred during the frame
module stream_accumulator
  import stream_acc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 10,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = cnt_width(COUNT);

  state_t             state_r, state_s;
  logic [ACC_W-1:0]   acc_r, acc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               ovf_r, ovf_s;
  logic               out_valid_s;
  logic [ACC_W-1:0]   out_sum_s;
  logic               out_ovf_s;
  logic               in_ready_s;

  logic               beat_s;
  logic [ACC_W-1:0]   rca_sum_s;
  logic               rca_cout_s;
  logic [ACC_W-1:0]   acc_add_s;
  logic               ovf_add_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  assign beat_s    = in_valid && in_ready;
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  acc_rca #(
    .W (ACC_W)
  ) u_rca (
    .a    (acc_r),
    .b    (ACC_W'(in_data)),
    .cin  (1'b0),
    .sum  (rca_sum_s),
    .cout (rca_cout_s)
  );

`ifdef STREAM_ACC_SATURATE_EN
  // Once any carry has been seen this frame the sum is pinned at full scale.
  assign acc_add_s = (rca_cout_s || ovf_r) ? {ACC_W{1'b1}} : rca_sum_s;
`else
  assign acc_add_s = rca_sum_s;
`endif
  assign ovf_add_s = ovf_r | rca_cout_s;

  // Next-state, datapath and result-register decode for the frame FSM.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    ovf_s       = ovf_r;
    out_valid_s = out_valid;
    out_sum_s   = out_sum;
    out_ovf_s   = out_ovf;
    case (state_r)
      IDLE, ACCUM: begin
        if (beat_s) begin
          acc_s = acc_add_s;
          ovf_s = ovf_add_s;
          cnt_s = cnt_inc_s;
          // The completing beat captures its own new sum, so the result is
          // visible one cycle after the last beat.
          if (cnt_inc_s == CNT_W'(COUNT)) begin
            state_s     = HOLD;
            out_valid_s = 1'b1;
            out_sum_s   = acc_add_s;
            out_ovf_s   = ovf_add_s;
          end else begin
            state_s = ACCUM;
          end
        end else begin
          state_s = state_r;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s     = IDLE;
          acc_s       = {ACC_W{1'b0}};
          cnt_s       = {CNT_W{1'b0}};
          ovf_s       = 1'b0;
          out_valid_s = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s     = IDLE;
        acc_s       = {ACC_W{1'b0}};
        cnt_s       = {CNT_W{1'b0}};
        ovf_s       = 1'b0;
        out_valid_s = 1'b0;
        out_sum_s   = {ACC_W{1'b0}};
        out_ovf_s   = 1'b0;
      end
    endcase
    // in_ready is registered, so it is decoded from the state being entered.
    in_ready_s = (state_s != HOLD);
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= {ACC_W{1'b0}};
      out_ovf   <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
      ovf_r     <= ovf_s;
      out_valid <= out_valid_s;
      out_sum   <= out_sum_s;
      out_ovf   <= out_ovf_s;
      in_ready  <= in_ready_s;
    end
  end

endmodule

// File: tb/tb_stream_accumulator.sv
// tb_stream_accumulator
// Three instances share clk/rst: #0 defaults, #1 ACC_W=9, #2 COUNT=1.
// A per-instance frame model (integer sum, beat count, held result) is
// compared against every instance on each falling edge; directed frames
// also compare against hand-computed totals.
module tb_stream_accumulator;

  logic       clk;
  logic       rst;
  logic [2:0] in_valid_v;
  logic [2:0] out_ready_v;
  logic [7:0] in_data_a [3];
  wire  [2:0] in_ready_v;
  wire  [2:0] out_valid_v;
  wire  [2:0] out_ovf_v;
  wire  [9:0] os0;
  wire  [8:0] os1;
  wire  [9:0] os2;
  logic [9:0] osum [3];

  int  n_vec;
  int  n_err;
  bit  chk_en;

  int  p_w   [3] = '{10, 9, 10};
  int  p_cnt [3] = '{4, 4, 1};
`ifdef STREAM_ACC_SATURATE_EN
  bit  sat = 1'b1;
  int  exp_t3 = 511;
`else
  bit  sat = 1'b0;
  int  exp_t3 = 288;
`endif

  int  m_sum [3];
  int  m_cnt [3];
  int  m_res [3];
  bit  m_ovf [3];
  bit  m_rovf [3];
  bit  m_hold [3];

  stream_accumulator dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data_a[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_sum(os0), .out_ovf(out_ovf_v[0]));

  stream_accumulator #(.DATA_W(8), .ACC_W(9), .COUNT(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data_a[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_sum(os1), .out_ovf(out_ovf_v[1]));

  stream_accumulator #(.DATA_W(8), .ACC_W(10), .COUNT(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data_a[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_sum(os2), .out_ovf(out_ovf_v[2]));

  assign osum[0] = os0;
  assign osum[1] = {1'b0, os1};
  assign osum[2] = os2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model compare, then advance the model with the inputs the next edge sees.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int t;
      int lim;
      if (chk_en) begin
        check($sformatf("in_ready%0d", k), in_ready_v[k], !m_hold[k]);
        check($sformatf("out_valid%0d", k), out_valid_v[k], m_hold[k]);
        if (m_hold[k]) begin
          check($sformatf("out_sum%0d", k), osum[k], m_res[k]);
          check($sformatf("out_ovf%0d", k), out_ovf_v[k], m_rovf[k]);
        end
      end
      if (rst) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0; m_hold[k] = 1'b0;
      end else if (m_hold[k]) begin
        if (out_ready_v[k]) begin
          m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0; m_hold[k] = 1'b0;
        end
      end else if (in_valid_v[k]) begin
        lim = 1 << p_w[k];
        t = m_sum[k] + int'(in_data_a[k]);
        if (t >= lim) begin
          m_ovf[k] = 1'b1;
          t = sat ? lim - 1 : t - lim;
        end
        m_sum[k] = t;
        m_cnt[k]++;
        if (m_cnt[k] == p_cnt[k]) begin
          m_hold[k] = 1'b1;
          m_res[k]  = t;
          m_rovf[k] = m_ovf[k];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand until accepted (bounded), then drop in_valid.
  task automatic send(input int k, input logic [7:0] d);
    bit got;
    int n;
    in_data_a[k]  = d;
    in_valid_v[k] = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      got = in_ready_v[k];
      tick();
      n++;
    end
    in_valid_v[k] = 1'b0;
    check($sformatf("send%0d_accepted", k), got, 1);
  endtask

  task automatic expect_result(input string tag, input int k, input int s, input bit o);
    check({tag, "_valid"}, out_valid_v[k], 1);
    check({tag, "_sum"}, osum[k], s);
    check({tag, "_ovf"}, out_ovf_v[k], o);
    check({tag, "_inready"}, in_ready_v[k], 0);
  endtask

  task automatic release_result(input string tag, input int k);
    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
    check({tag, "_rel_valid"}, out_valid_v[k], 0);
    check({tag, "_rel_inready"}, in_ready_v[k], 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    in_valid_v = 3'b000;
    out_ready_v = 3'b000;
    for (int k = 0; k < 3; k++) in_data_a[k] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_inready", in_ready_v, 3'b111);
    check("reset_outvalid", out_valid_v, 3'b000);
    check("reset_sum0", osum[0], 0);

    // 1: back-to-back 1,2,3,4
    send(0, 8'd1); send(0, 8'd2); send(0, 8'd3); send(0, 8'd4);
    expect_result("t1", 0, 10, 1'b0);

    // 2: hold with in_valid asserted, then 255 x4
    in_data_a[0] = 8'd99;
    in_valid_v[0] = 1'b1;
    repeat (5) tick();
    expect_result("t2_hold", 0, 10, 1'b0);
    in_valid_v[0] = 1'b0;
    release_result("t2a", 0);
    for (int i = 0; i < 4; i++) send(0, 8'd255);
    expect_result("t2", 0, 1020, 1'b0);
    release_result("t2b", 0);

    // 3: 9-bit accumulator overflow
    for (int i = 0; i < 4; i++) send(1, 8'd200);
    expect_result("t3", 1, exp_t3, 1'b1);
    release_result("t3", 1);

    // 4: in_valid every other cycle
    for (int i = 0; i < 4; i++) begin
      send(0, 8'd7);
      if (i < 3) begin
        check("t4_pending", out_valid_v[0], 0);
        tick();
      end
    end
    expect_result("t4", 0, 28, 1'b0);
    release_result("t4", 0);

    // 5: reset mid-frame
    send(0, 8'd9); send(0, 8'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_after_rst", out_valid_v[0], 0);
    for (int i = 0; i < 4; i++) send(0, 8'd5);
    expect_result("t5", 0, 20, 1'b0);
    release_result("t5", 0);

    // 6: COUNT=1
    send(2, 8'd3);
    expect_result("t6a", 2, 3, 1'b0);
    release_result("t6a", 2);
    send(2, 8'd6);
    expect_result("t6b", 2, 6, 1'b0);
    release_result("t6b", 2);

    // Random traffic on all instances, with occasional resets.
    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        in_valid_v[k]  = 1'($urandom_range(0, 1));
        out_ready_v[k] = 1'($urandom_range(0, 1));
        in_data_a[k]   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(180, 255));
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid_v = 3'b000;
    out_ready_v = 3'b000;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
